// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, its binary index, and an
// optional hold limit that forces the owner to give way after HOLD_MAX cycles.
module onehot_rr_arbiter #(
  parameter  int N        = 8,
  parameter  int HOLD_MAX = 0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             expired
);

  localparam int HC_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);
  localparam bit HOLD_EN = (HOLD_MAX != 0);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             owner_req;
  logic             take_grant;

  // Search order starts at ptr and wraps; N is a power of two so the add wraps for free.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_req  = req[grant_idx];
    // A fresh grant happens from IDLE/GAP, or on release with no idle bubble.
    take_grant = win_found && ((state != GRANT) || !owner_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (take_grant) begin
        state       <= GRANT;
        grant       <= N'(1) << win_idx;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
        ptr         <= win_idx + IDX_W'(1);
        hold_cnt    <= HOLD_EN ? HC_W'(1) : '0;
      end else if (state == GRANT && owner_req) begin
        if (HOLD_EN && hold_cnt == HOLD_LIM) begin
          state       <= GAP;
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
          expired     <= 1'b1;
        end else if (HOLD_EN && hold_cnt != HOLD_LIM) begin
          hold_cnt <= hold_cnt + HC_W'(1);
        end
      end else begin
        state       <= IDLE;
        grant       <= '0;
        grant_idx   <= '0;
        grant_valid <= 1'b0;
        hold_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed and randomized bench for onehot_rr_arbiter (N=8, HOLD_MAX=4) against an
// integer-level round-robin reference model.
module tb_onehot_rr_arbiter;

  localparam int N  = 8;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         grant_valid;
  logic         expired;

  int checks = 0;
  int errors = 0;

  // Reference model: owner as an integer (-1 = none), pointer, hold count, gap pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_exp   = 1'b0;
  int wait_cnt[N];

  onehot_rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int enc(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_exp   = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    for (int i = 0; i < N; i++) if (!r[i]) wait_cnt[i] = 0;
    if (m_owner >= 0 && r[m_owner]) begin
      if (m_hold == HM) begin
        m_owner = -1;
        m_exp   = 1'b1;
      end else begin
        m_exp = 1'b0;
        if (m_hold < HM) m_hold++;
      end
    end else begin
      m_exp = 1'b0;
      w = arb(r, m_ptr);
      m_owner = w;
      if (w >= 0) begin
        m_ptr  = (w + 1) % N;
        m_hold = 1;
        for (int i = 0; i < N; i++) begin
          if (i == w) wait_cnt[i] = 0;
          else if (r[i]) begin
            wait_cnt[i]++;
            chk("starve", 32'(wait_cnt[i] < N), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(req);
    #1;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("idx_enc", 32'(grant_idx), 32'(enc(grant)));
  endtask

  task automatic set_req(input logic [N-1:0] v);
    @(negedge clk);
    req = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] mask;

    // T1: single request from reset, then pointer check via next winner.
    do_reset();
    set_req(8'h00); tick();
    set_req(8'h08); tick();
    chk("t1_grant", 32'(grant), 32'h08);
    chk("t1_idx", 32'(grant_idx), 32'd3);
    chk("t1_valid", 32'(grant_valid), 32'd1);
    set_req(8'h11); tick();
    chk("t1_ptr_next", 32'(grant_idx), 32'd4);

    // T2: all requesting, each owner releases after two cycles; no idle bubbles.
    do_reset();
    set_req(8'hFF);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t2_idx", 32'(grant_idx), 32'(k % N));
      chk("t2_valid", 32'(grant_valid), 32'd1);
      tick();
      chk("t2_hold", 32'(grant_idx), 32'(k % N));
      set_req(8'hFF & ~(8'h01 << (k % N)));
    end

    // T3: wrap-around search from ptr=7.
    do_reset();
    set_req(8'h40); tick();
    chk("t3_own6", 32'(grant_idx), 32'd6);
    set_req(8'h00); tick();
    chk("t3_idle", 32'(grant_valid), 32'd0);
    set_req(8'h41); tick();
    chk("t3_wrap", 32'(grant), 32'h01);

    // T4: hold limit forces a gap, then rotation to the other requester.
    do_reset();
    set_req(8'h20); tick();
    chk("t4_g5", 32'(grant), 32'h20);
    set_req(8'h24);
    repeat (3) begin
      tick();
      chk("t4_g5", 32'(grant), 32'h20);
    end
    tick();
    chk("t4_gap_grant", 32'(grant), 32'h00);
    chk("t4_gap_exp", 32'(expired), 32'd1);
    tick();
    chk("t4_next_grant", 32'(grant), 32'h04);
    chk("t4_next_idx", 32'(grant_idx), 32'd2);
    chk("t4_next_exp", 32'(expired), 32'd0);

    // T5: asynchronous reset mid-grant.
    do_reset();
    set_req(8'h20); tick();
    chk("t5_g5", 32'(grant), 32'h20);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_grant", 32'(grant), 32'h00);
    chk("t5_rst_idx", 32'(grant_idx), 32'd0);
    chk("t5_rst_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h21;
    tick();
    chk("t5_after", 32'(grant), 32'h01);

    // T6: random request toggling checked against the model every cycle.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      mask = '0;
      for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) set_req('0);
      else set_req(req ^ mask);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
